unpool: RTL and testbench

- Inverse of the max-pool reducer: expands each upstream value into a burst of identical output samples (nearest-neighbour upsample / max-unpool) for the decode/upsample layers of the CNN datapath.
- Ready/valid on both sides; burst length is runtime-configurable and latched per input value.
- Sits between a feature-map buffer read port and the convolution input stream.

---
 rtl/unpool.sv | 85 ++++++++
 tb/tb_unpool.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpool.sv
// rtl/unpool.sv - ready/valid burst replicator (nearest-neighbour upsample / max-unpool)
// Define UNPOOL_ZERO_FILL_EN for max-unpool mode: only the first copy of a burst carries the value.
module unpool #(
   parameter int NUM_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CNT_WIDTH-1:0] cfg_repeat,
   input  logic [NUM_WIDTH-1:0] up_data,
   input  logic                 up_valid,
   output logic                 up_ready,
   output logic [NUM_WIDTH-1:0] dn_data,
   output logic                 dn_valid,
   input  logic                 dn_ready,
   output logic                 dn_last,
   output logic                 busy
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t               state, state_nxt;
   logic [NUM_WIDTH-1:0] hold;
   logic [CNT_WIDTH-1:0] count;
   logic                 up_fire, dn_fire;

   assign up_fire = up_valid & up_ready;
   assign dn_fire = dn_valid & dn_ready;

   // dn_ready -> up_ready is the only combinational path; it enables zero-bubble bursts.
   always_comb begin
      state_nxt = state;
      up_ready  = 1'b0;
      dn_valid  = 1'b0;
      dn_last   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            up_ready = rst_n;
            if (up_valid) state_nxt = EMIT;
         end
         EMIT: begin
            dn_valid = 1'b1;
            busy     = 1'b1;
            dn_last  = (count == CNT_WIDTH'(1));
            if (count == CNT_WIDTH'(1) && dn_ready) begin
               up_ready = rst_n;
               if (!up_valid) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hold  <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (up_fire) begin
            hold  <= up_data;
            count <= (cfg_repeat == '0) ? CNT_WIDTH'(1) : cfg_repeat;
         end else if (dn_fire && count != '0) begin
            count <= count - CNT_WIDTH'(1);
         end
      end
   end

`ifdef UNPOOL_ZERO_FILL_EN
   logic first;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       first <= 1'b0;
      else if (up_fire) first <= 1'b1;
      else if (dn_fire) first <= 1'b0;
   end

   assign dn_data = first ? hold : '0;
`else
   assign dn_data = hold;
`endif

endmodule

// File: tb/tb_unpool.sv
// tb/tb_unpool.sv - randomized and directed bench for unpool against a burst-queue model
module tb_unpool;

`ifdef UNPOOL_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cfg_repeat = 8'd0;
   logic [15:0] up_data = 16'd0;
   logic        up_valid = 1'b0;
   logic        up_ready;
   logic [15:0] dn_data;
   logic        dn_valid;
   logic        dn_ready = 1'b1;
   logic        dn_last;
   logic        busy;

   unpool #(.NUM_WIDTH(16), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_repeat(cfg_repeat),
      .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
      .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
      .dn_last(dn_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {logic [15:0] data; logic last;} exp_t;
   typedef struct {int cyc; logic [15:0] data; logic last;} beat_t;

   exp_t  exp_q[$];
   beat_t cap[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    last_acc = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = 16'd0;
   logic        prev_last = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] copy_val(input logic [15:0] base, input int idx);
      return (ZF && idx > 0) ? 16'd0 : base;
   endfunction

   always @(posedge clk) cyc++;

   // Model: each upstream accept queues its whole burst; every output beat must match the queue head.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_dn_valid", {31'd0, dn_valid}, 32'd0);
         chk("rst_dn_last", {31'd0, dn_last}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_up_ready", {31'd0, up_ready}, 32'd0);
         chk("rst_dn_data", {16'd0, dn_data}, 32'd0);
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         chk("dn_valid", {31'd0, dn_valid}, {31'd0, exp_q.size() != 0});
         chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) begin
            chk("up_ready_emit", {31'd0, up_ready}, {31'd0, dn_ready && exp_q[0].last});
            chk("dn_last", {31'd0, dn_last}, {31'd0, exp_q[0].last});
            chk("dn_data", {16'd0, dn_data}, {16'd0, exp_q[0].data});
         end else begin
            chk("up_ready_idle", {31'd0, up_ready}, 32'd1);
            chk("dn_last_idle", {31'd0, dn_last}, 32'd0);
         end
         if (prev_stall) begin
            chk("stall_data", {16'd0, dn_data}, {16'd0, prev_data});
            chk("stall_last", {31'd0, dn_last}, {31'd0, prev_last});
         end
         if (dn_valid && dn_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            cap.push_back('{cyc: cyc, data: dn_data, last: dn_last});
         end
         if (up_valid && up_ready) begin
            int n;
            n = (cfg_repeat == 8'd0) ? 1 : int'(cfg_repeat);
            for (int i = 0; i < n; i++)
               exp_q.push_back('{data: copy_val(up_data, i), last: (i == n - 1)});
         end
         prev_stall = dn_valid && !dn_ready;
         prev_data  = dn_data;
         prev_last  = dn_last;
      end
   end

   task automatic send(input logic [15:0] d);
      int t;
      up_data  = d;
      up_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!up_ready && t < 500);
      if (t >= 500) chk("send_timeout", 32'd0, 32'd1);
      last_acc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((exp_q.size() != 0 || dn_valid) && t < 2000);
      if (t >= 2000) chk("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input int n);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (cap.size() < n && t < 500);
      if (t >= 500) chk("beat_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string name, input int i, input logic [15:0] d, input logic l);
      if (cap.size() > i) begin
         chk({name, "_data"}, {16'd0, cap[i].data}, {16'd0, d});
         chk({name, "_last"}, {31'd0, cap[i].last}, {31'd0, l});
      end else begin
         chk({name, "_missing"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      logic acc;
      int   p[6];
      int   acc1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // burst of four
      cfg_repeat = 8'd4;
      cap.delete();
      send(16'h1234);
      up_valid = 1'b0;
      drain();
      chk("t1_count", cap.size(), 32'd4);
      if (cap.size() > 0) chk("t1_latency", cap[0].cyc, last_acc + 1);
      chk_beat("t1_b0", 0, 16'h1234, 1'b0);
      chk_beat("t1_b1", 1, ZF ? 16'h0 : 16'h1234, 1'b0);
      chk_beat("t1_b3", 3, ZF ? 16'h0 : 16'h1234, 1'b1);
      chk("t1_idle_valid", {31'd0, dn_valid}, 32'd0);
      chk("t1_idle_busy", {31'd0, busy}, 32'd0);

      // back-to-back bursts of two
      cfg_repeat = 8'd2;
      cap.delete();
      send(16'h0001);
      send(16'h0002);
      send(16'h0003);
      up_valid = 1'b0;
      drain();
      chk("t2_count", cap.size(), 32'd6);
      for (int i = 0; i < 6; i++)
         chk_beat("t2", i, (ZF && i % 2 == 1) ? 16'h0 : 16'(i / 2 + 1), i % 2 == 1);
      for (int i = 1; i < cap.size(); i++)
         chk("t2_no_bubble", cap[i].cyc, cap[i-1].cyc + 1);

      // backpressure
      cfg_repeat = 8'd3;
      cap.delete();
      send(16'hFFFF);
      up_valid = 1'b0;
      p = '{1, 0, 0, 1, 0, 1};
      for (int i = 0; i < 6; i++) begin
         dn_ready = p[i][0];
         @(posedge clk);
         #1;
      end
      chk("t3_count", cap.size(), 32'd3);
      chk("t3_done_valid", {31'd0, dn_valid}, 32'd0);
      dn_ready = 1'b1;
      drain();
      chk_beat("t3_b0", 0, 16'hFFFF, 1'b0);
      chk_beat("t3_b2", 2, ZF ? 16'h0 : 16'hFFFF, 1'b1);

      // repeat 0 and 1: single copy per input, full throughput
      for (int r = 0; r < 2; r++) begin
         cfg_repeat = 8'(r);
         cap.delete();
         send(16'h8000);
         send(16'h7FFF);
         up_valid = 1'b0;
         drain();
         chk("t4_count", cap.size(), 32'd2);
         chk_beat("t4_b0", 0, 16'h8000, 1'b1);
         chk_beat("t4_b1", 1, 16'h7FFF, 1'b1);
         if (cap.size() == 2) chk("t4_rate", cap[1].cyc, cap[0].cyc + 1);
      end

      // cfg change mid-burst
      cfg_repeat = 8'd5;
      cap.delete();
      send(16'h0055);
      up_valid = 1'b0;
      wait_beats(1);
      cfg_repeat = 8'd2;
      send(16'h0066);
      up_valid = 1'b0;
      drain();
      chk("t5_count", cap.size(), 32'd7);
      chk_beat("t5_b3", 3, ZF ? 16'h0 : 16'h0055, 1'b0);
      chk_beat("t5_b4", 4, ZF ? 16'h0 : 16'h0055, 1'b1);
      chk_beat("t5_b5", 5, 16'h0066, 1'b0);
      chk_beat("t5_b6", 6, ZF ? 16'h0 : 16'h0066, 1'b1);

      // reset mid-burst
      cfg_repeat = 8'd4;
      cap.delete();
      send(16'h0077);
      up_valid = 1'b0;
      wait_beats(2);
      rst_n = 1'b0;
      #1;
      chk("t6_valid", {31'd0, dn_valid}, 32'd0);
      chk("t6_last", {31'd0, dn_last}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_up_ready", {31'd0, up_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      cap.delete();
      cfg_repeat = 8'd1;
      send(16'h0042);
      up_valid = 1'b0;
      drain();
      chk("t6_count", cap.size(), 32'd1);
      chk_beat("t6_b0", 0, 16'h0042, 1'b1);

      // randomized traffic, cfg may change at any time
      acc1 = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         acc = up_valid && up_ready;
         if (acc) acc1++;
         @(posedge clk);
         #1;
         if (acc || !up_valid) begin
            up_valid = ($urandom_range(0, 3) != 0);
            up_data  = 16'($urandom);
         end
         dn_ready   = ($urandom_range(0, 3) != 0);
         cfg_repeat = ($urandom_range(0, 60) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      end
      up_valid = 1'b0;
      dn_ready = 1'b1;
      drain();
      chk("rand_accepts_seen", {31'd0, acc1 > 50}, 32'd1);
      chk("final_queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
